// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared constants and state encoding for the boot loader /
// instruction-memory responder.
//   IMB_INST_WIDTH  instruction / loader byte width
//   IMB_INST_DEPTH  instruction address width
//   IMB_RST_HOLD    cycles cpu_rst stays high after a good checksum
//   imb_state_e     loader FSM states
package imem_boot_pkg;
  localparam int IMB_INST_WIDTH  = 8;
  localparam int IMB_INST_DEPTH  = 8;
  localparam int IMB_RST_HOLD    = 2;
  localparam int IMB_STATE_WIDTH = 3;

  typedef enum logic [IMB_STATE_WIDTH-1:0] {
    IMB_LOAD    = 3'd0,
    IMB_CHECK   = 3'd1,
    IMB_RELEASE = 3'd2,
    IMB_RUN     = 3'd3,
    IMB_ERROR   = 3'd4
  } imb_state_e;
endpackage

// File: rtl/imem_boot_array.sv
// imem_boot_array: program storage, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk_i               write clock
//   we_i/waddr_i/wdata_i write port
//   raddr_i/rdata_o     zero-latency read port
module imem_boot_array #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [A-1:0] raddr_i,
  output logic [W-1:0] rdata_o
);
  logic [W-1:0] mem [2**A];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/imem_boot.sv
// imem_boot: accepts a program over a byte-wide valid/ready port while the CPU
// is held in reset, verifies a two's-complement checksum, then releases the
// CPU and serves instructions combinationally from the stored program.
//   clk_i, rst_ni       clock, async active-low reset
//   ld_valid_i/ld_ready_o/ld_data_i/ld_last_i  loader handshake
//   reload_i            restart loading (any state)
//   imem_addr_i/imem_data_o  instruction fetch (data is 0 outside RUN)
//   cpu_rst_o           active-high CPU reset
//   load_err_o          sticky checksum/overflow error
//   prog_len_o          number of program bytes stored
module imem_boot
  import imem_boot_pkg::*;
#(
  parameter int INST_WIDTH = IMB_INST_WIDTH,
  parameter int INST_DEPTH = IMB_INST_DEPTH,
  parameter int RST_HOLD   = IMB_RST_HOLD
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [INST_WIDTH-1:0] ld_data_i,
  input  logic                  ld_last_i,
  input  logic                  reload_i,
  input  logic [INST_DEPTH-1:0] imem_addr_i,
  output logic [INST_WIDTH-1:0] imem_data_o,
  output logic                  cpu_rst_o,
  output logic                  load_err_o,
  output logic [INST_DEPTH:0]   prog_len_o
);
  localparam int MEM_WORDS = 2**INST_DEPTH;
  localparam int PTR_W     = INST_DEPTH + 1;
  localparam int CNT_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  imb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [INST_WIDTH-1:0] sum_q, sum_d, sum_nxt;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ld_ready_q, cpu_rst_q, load_err_q;
  logic                  accept, we;
  logic [INST_WIDTH-1:0] rdata;

  assign accept  = ld_valid_i & ld_ready_q;
  // Truncated to byte width so the checksum test is mod 256.
  assign sum_nxt = sum_q + ld_data_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    if (reload_i) begin
      // Takes priority over any handshake in the same cycle.
      state_d = IMB_LOAD;
      ptr_d   = '0;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IMB_LOAD: if (accept) begin
          we    = 1'b1;
          sum_d = sum_nxt;
          ptr_d = ptr_q + 1'b1;
          if (ld_last_i)                                state_d = IMB_CHECK;
          else if (ptr_q == PTR_W'(MEM_WORDS - 1))      state_d = IMB_ERROR;
        end
        IMB_CHECK: if (accept) begin
          if (sum_nxt == '0) begin
            state_d = IMB_RELEASE;
            cnt_d   = '0;
          end else begin
            state_d = IMB_ERROR;
          end
        end
        IMB_RELEASE: begin
          if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = IMB_RUN;
          else                               cnt_d   = cnt_q + 1'b1;
        end
        IMB_RUN, IMB_ERROR: ;
        default: state_d = IMB_ERROR;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IMB_LOAD;
      ptr_q      <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      ld_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      ld_ready_q <= (state_d == IMB_LOAD) || (state_d == IMB_CHECK);
      cpu_rst_q  <= (state_d != IMB_RUN);
      load_err_q <= (state_d == IMB_ERROR);
    end
  end

  imem_boot_array #(.W(INST_WIDTH), .A(INST_DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (ptr_q[INST_DEPTH-1:0]),
    .wdata_i (ld_data_i),
    .raddr_i (imem_addr_i),
    .rdata_o (rdata)
  );

  // ptr always equals the number of bytes stored in the current load.
  assign prog_len_o  = ptr_q;
  assign ld_ready_o  = ld_ready_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign load_err_o  = load_err_q;
  assign imem_data_o = (state_q == IMB_RUN) ? rdata : '0;
endmodule

// File: tb/tb_imem_boot.sv
// tb_imem_boot: directed tests for imem_boot with hand-computed expectations.
module tb_imem_boot;
  logic       clk, rst_n, ld_valid, ld_ready, ld_last, reload, cpu_rst, load_err;
  logic [7:0] ld_data, imem_addr, imem_data;
  logic [8:0] prog_len;
  int vectors = 0, miscompares = 0;

  imem_boot dut (
    .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_ready_o(ld_ready),
    .ld_data_i(ld_data), .ld_last_i(ld_last), .reload_i(reload),
    .imem_addr_i(imem_addr), .imem_data_o(imem_data), .cpu_rst_o(cpu_rst),
    .load_err_o(load_err), .prog_len_o(prog_len)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic pulse_reload();
    reload = 1; tick(); reload = 0;
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_rst got %b exp 1", cpu_rst); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ld_ready got %b exp 1", ld_ready); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL rst_load_err got %b exp 0", load_err); end
    vectors++; if (prog_len !== 9'd0) begin miscompares++; $display("FAIL rst_prog_len got %0d exp 0", prog_len); end
    vectors++; if (imem_data !== 8'h00) begin miscompares++; $display("FAIL rst_imem_data got %h exp 00", imem_data); end
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic test_nominal();
    send_byte(8'h01, 0); send_byte(8'hAE, 0); send_byte(8'h02, 1);
    vectors++; if (prog_len !== 9'd3) begin miscompares++; $display("FAIL nom_len got %0d exp 3", prog_len); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL nom_ready_check got %b exp 1", ld_ready); end
    send_byte(8'h4F, 0);
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL nom_rel0_rst got %b exp 1", cpu_rst); end
    vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL nom_rel_ready got %b exp 0", ld_ready); end
    imem_addr = 8'd0; tick();
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL nom_rel1_rst got %b exp 1", cpu_rst); end
    vectors++; if (imem_data !== 8'h00) begin miscompares++; $display("FAIL nom_rel_data got %h exp 00", imem_data); end
    tick();
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL nom_run_rst got %b exp 0", cpu_rst); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL nom_err got %b exp 0", load_err); end
    imem_addr = 8'd0; #1;
    vectors++; if (imem_data !== 8'h01) begin miscompares++; $display("FAIL nom_rd0 got %h exp 01", imem_data); end
    imem_addr = 8'd1; #1;
    vectors++; if (imem_data !== 8'hAE) begin miscompares++; $display("FAIL nom_rd1 got %h exp ae", imem_data); end
    imem_addr = 8'd2; #1;
    vectors++; if (imem_data !== 8'h02) begin miscompares++; $display("FAIL nom_rd2 got %h exp 02", imem_data); end
  endtask

  task automatic test_valid_in_run();
    ld_valid = 1; ld_data = 8'h55; ld_last = 1;
    tick(); tick(); tick();
    ld_valid = 0; ld_last = 0;
    imem_addr = 8'd0; #1;
    vectors++; if (prog_len !== 9'd3) begin miscompares++; $display("FAIL run_vld_len got %0d exp 3", prog_len); end
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL run_vld_rst got %b exp 0", cpu_rst); end
    vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL run_vld_ready got %b exp 0", ld_ready); end
    vectors++; if (imem_data !== 8'h01) begin miscompares++; $display("FAIL run_vld_rd0 got %h exp 01", imem_data); end
  endtask

  task automatic test_reload();
    pulse_reload();
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL rl_rst got %b exp 1", cpu_rst); end
    vectors++; if (prog_len !== 9'd0) begin miscompares++; $display("FAIL rl_len got %0d exp 0", prog_len); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL rl_ready got %b exp 1", ld_ready); end
    vectors++; if (imem_data !== 8'h00) begin miscompares++; $display("FAIL rl_data got %h exp 00", imem_data); end
    // reload together with a handshake: byte must be dropped
    ld_valid = 1; ld_data = 8'h77; ld_last = 1; reload = 1;
    tick();
    ld_valid = 0; ld_last = 0; reload = 0;
    vectors++; if (prog_len !== 9'd0) begin miscompares++; $display("FAIL rl_drop_len got %0d exp 0", prog_len); end
    send_byte(8'h05, 1);
    vectors++; if (prog_len !== 9'd1) begin miscompares++; $display("FAIL rl_len1 got %0d exp 1", prog_len); end
    send_byte(8'hFB, 0);
    tick(); tick();
    imem_addr = 8'd0; #1;
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL rl_run_rst got %b exp 0", cpu_rst); end
    vectors++; if (imem_data !== 8'h05) begin miscompares++; $display("FAIL rl_rd0 got %h exp 05", imem_data); end
  endtask

  task automatic test_bad_checksum();
    pulse_reload();
    send_byte(8'h01, 0); send_byte(8'hAE, 0); send_byte(8'h02, 1); send_byte(8'h50, 0);
    imem_addr = 8'd1; #1;
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL bad_err got %b exp 1", load_err); end
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL bad_rst got %b exp 1", cpu_rst); end
    vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL bad_ready got %b exp 0", ld_ready); end
    vectors++; if (imem_data !== 8'h00) begin miscompares++; $display("FAIL bad_data got %h exp 00", imem_data); end
    tick(); tick();
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL bad_hold_rst got %b exp 1", cpu_rst); end
    ld_valid = 1; ld_data = 8'h00; ld_last = 1;
    tick(); tick();
    ld_valid = 0; ld_last = 0;
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL bad_sticky got %b exp 1", load_err); end
    vectors++; if (prog_len !== 9'd3) begin miscompares++; $display("FAIL bad_len got %0d exp 3", prog_len); end
  endtask

  task automatic test_gaps();
    pulse_reload();
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL gap_err_clr got %b exp 0", load_err); end
    ld_valid = 1; ld_data = 8'h10; tick();
    ld_valid = 0; ld_data = 8'h99; tick(); tick();
    vectors++; if (prog_len !== 9'd1) begin miscompares++; $display("FAIL gap_len1 got %0d exp 1", prog_len); end
    ld_valid = 1; ld_data = 8'h20; tick();
    ld_valid = 0; ld_data = 8'h88; ld_last = 1; tick();
    ld_valid = 1; ld_data = 8'h30; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    vectors++; if (prog_len !== 9'd3) begin miscompares++; $display("FAIL gap_len3 got %0d exp 3", prog_len); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL gap_ready got %b exp 1", ld_ready); end
    tick();
    send_byte(8'hA0, 0);
    tick(); tick();
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL gap_run_rst got %b exp 0", cpu_rst); end
    imem_addr = 8'd0; #1;
    vectors++; if (imem_data !== 8'h10) begin miscompares++; $display("FAIL gap_rd0 got %h exp 10", imem_data); end
    imem_addr = 8'd1; #1;
    vectors++; if (imem_data !== 8'h20) begin miscompares++; $display("FAIL gap_rd1 got %h exp 20", imem_data); end
    imem_addr = 8'd2; #1;
    vectors++; if (imem_data !== 8'h30) begin miscompares++; $display("FAIL gap_rd2 got %h exp 30", imem_data); end
  endtask

  task automatic test_overflow();
    pulse_reload();
    for (int i = 0; i < 255; i++) send_byte(i[7:0], 0);
    vectors++; if (prog_len !== 9'd255) begin miscompares++; $display("FAIL ovf_len255 got %0d exp 255", prog_len); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL ovf_ready255 got %b exp 1", ld_ready); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err255 got %b exp 0", load_err); end
    send_byte(8'hFF, 0);
    vectors++; if (prog_len !== 9'd256) begin miscompares++; $display("FAIL ovf_len got %0d exp 256", prog_len); end
    vectors++; if (load_err !== 1'b1) begin miscompares++; $display("FAIL ovf_err got %b exp 1", load_err); end
    vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ready got %b exp 0", ld_ready); end
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL ovf_rst got %b exp 1", cpu_rst); end
  endtask

  task automatic test_async_reset();
    pulse_reload();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    vectors++; if (prog_len !== 9'd2) begin miscompares++; $display("FAIL ar_pre_len got %0d exp 2", prog_len); end
    #2; rst_n = 0; #1;
    vectors++; if (prog_len !== 9'd0) begin miscompares++; $display("FAIL ar_len got %0d exp 0", prog_len); end
    vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL ar_rst got %b exp 1", cpu_rst); end
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL ar_ready got %b exp 1", ld_ready); end
    vectors++; if (load_err !== 1'b0) begin miscompares++; $display("FAIL ar_err got %b exp 0", load_err); end
    @(posedge clk); #1; rst_n = 1;
    send_byte(8'h05, 1); send_byte(8'hFB, 0);
    tick(); tick();
    vectors++; if (cpu_rst !== 1'b0) begin miscompares++; $display("FAIL ar_run_rst got %b exp 0", cpu_rst); end
    vectors++; if (prog_len !== 9'd1) begin miscompares++; $display("FAIL ar_run_len got %0d exp 1", prog_len); end
    imem_addr = 8'd0; #1;
    vectors++; if (imem_data !== 8'h05) begin miscompares++; $display("FAIL ar_rd0 got %h exp 05", imem_data); end
    // word 1 keeps the byte from the aborted load
    imem_addr = 8'd1; #1;
    vectors++; if (imem_data !== 8'hBB) begin miscompares++; $display("FAIL ar_rd1_stale got %h exp bb", imem_data); end
  endtask

  initial begin
    rst_n = 0; ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0; imem_addr = 0;
    test_reset();
    test_nominal();
    test_valid_in_run();
    test_reload();
    test_bad_checksum();
    test_gaps();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_boot.md
Name: imem_boot

Overview:
Instruction-memory responder for the CPU core (mcu/regs/pc/alu). It answers the PC's imem_addr with imem_data, replacing the stimulus the testbenches drive by hand. While the CPU is held in reset it accepts a program over a byte-wide valid/ready loader port and verifies a two's-complement checksum. On success it releases the CPU reset and serves instructions.

Parameters:
INST_WIDTH, 8, instruction/loader byte width (`INST_WIDTH).
INST_DEPTH, 8, instruction address width (`INST_DEPTH).
MEM_WORDS, 256, program storage words (2**INST_DEPTH).
RST_HOLD, 2, cycles cpu_rst stays high after checksum pass.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  asynchronous, active-low reset.
ld_valid  in  1  loader byte valid.
ld_ready  out  1  loader byte accepted when ld_valid & ld_ready.
ld_data  in  INST_WIDTH  program byte, or checksum byte in CHECK.
ld_last  in  1  marks final program byte; qualified by handshake.
reload  in  1  single-cycle request to restart loading.
imem_addr  in  INST_DEPTH  current program address from pc.
imem_data  out  INST_WIDTH  instruction to regs/pc.
cpu_rst  out  1  active-high reset to mcu/regs/pc.
load_err  out  1  checksum fail or overflow, sticky until reload.
prog_len  out  INST_DEPTH+1  number of program bytes stored.

Behaviour:
- Reset (rst=0, async): state=LOAD, ptr=0, sum=0, cnt=0, cpu_rst=1, ld_ready=1, load_err=0, prog_len=0. Memory array is not cleared.
- ld_ready=1 only in LOAD and CHECK. A byte is accepted on a clk edge with ld_valid & ld_ready.
- LOAD, on accept:
  - mem[ptr] <= ld_data; sum <= sum + ld_data (mod 256); ptr <= ptr+1; prog_len <= ptr+1.
  - ld_last=1 -> CHECK.
  - ld_last=0 on the byte written at ptr=MEM_WORDS-1 -> ERROR (overflow; that byte is still written).
- CHECK:
  - The next accepted byte is the checksum; ld_last is ignored.
  - (sum + byte) mod 256 == 0 -> RELEASE with cnt=0; otherwise -> ERROR.
- RELEASE: cpu_rst=1; cnt increments each cycle; when cnt==RST_HOLD-1 -> RUN. cpu_rst drops in the first RUN cycle.
- RUN:
  - cpu_rst=0, ld_ready=0.
  - imem_data = mem[imem_addr], combinational (zero latency, same cycle as address).
  - Reads of addresses >= prog_len return stale contents; no checking.
- ERROR: cpu_rst=1, load_err=1, ld_ready=0.
- Outside RUN, imem_data=0.
- reload=1 in any state:
  - Next state=LOAD; ptr, sum and prog_len cleared; load_err cleared.
  - cpu_rst is high from the next edge.
  - reload overrides a handshake in the same cycle; that byte is dropped.
- ld_valid in RUN, ERROR or RELEASE is ignored; no state change.
- Minimum program is 1 byte (ld_last on the first byte). Zero-length programs are not supported.
- Async reset mid-load aborts immediately. Previously written memory words stay but are invalid.

Decomposition:
- defs.v gains the state encodings IMB_LOAD, IMB_CHECK, IMB_RELEASE, IMB_RUN, IMB_ERROR (3-bit) and IMB_STATE_WIDTH.
- Sub-module imem_array: MEM_WORDS x INST_WIDTH registers, one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). No reset.
- imem_boot holds the FSM, ptr, sum, hold counter and output muxing.

Test Plan:
1. Nominal load: rst released; bytes 0x01, 0xAE, 0x02(last), checksum 0x4F -> prog_len=3. RST_HOLD cycles later cpu_rst=0. imem_addr=0/1/2 -> imem_data 0x01/0xAE/0x02.
2. Bad checksum: same program, checksum 0x50 -> load_err=1, cpu_rst stays 1, ld_ready=0, imem_data=0.
3. Backpressure and gaps: ld_valid toggled with idle cycles between bytes -> only handshaken bytes stored; ld_valid asserted in RUN -> no change.
4. Overflow: 256 bytes with ld_last=0 -> ERROR after the 256th byte, prog_len=256, load_err=1.
5. Reload: in RUN, pulse reload, then load 0x05(last), checksum 0xFB -> cpu_rst high the cycle after reload. After release, mem[0]=0x05 and prog_len=1. reload coincident with a handshake drops that byte.
6. Async reset mid-load: assert rst after 2 bytes, between clock edges -> outputs go to reset values immediately (cpu_rst=1, prog_len=0, ld_ready=1); a fresh load succeeds.
